// File: rtl/rd_tracker_multi_pkg.sv
// rd_tracker_multi_pkg: shared constants and disparity width helper for the RD tracker
package rd_tracker_multi_pkg;
  localparam logic RD_MINUS = 1'b0;
  localparam logic RD_PLUS = 1'b1;
  localparam int MODE_INDEP = 0;
  localparam int MODE_CHAIN = 1;
  function automatic int disp_w(input int sym_w);
    return $clog2(sym_w) + 2;
  endfunction
endpackage

// File: rtl/rd_tracker_multi_sym_disp_step.sv
// sym_disp_step: symbol disparity (stage 1) and RD rule/check on the registered disparity (stage 2)
module sym_disp_step
  import rd_tracker_multi_pkg::*;
#(
  parameter int SYM_W = 10,
  parameter int DW = disp_w(SYM_W)
) (
  input  logic [SYM_W-1:0]    sym,
  output logic signed [DW-1:0] d,
  input  logic signed [DW-1:0] d_q,
  input  logic                rd_in,
  output logic                rd_out,
  output logic                err
);
  localparam logic signed [DW-1:0] P2 = DW'(2);
  localparam logic signed [DW-1:0] M2 = -P2;
  logic zero, flip;
  always_comb begin
    d = '0;
    for (int i = 0; i < SYM_W; i++) d = d + DW'(sym[i]);
    d = (d <<< 1) - DW'(SYM_W);
  end
  assign zero = d_q == '0;
  assign flip = (d_q == P2 && rd_in == RD_MINUS) || (d_q == M2 && rd_in == RD_PLUS);
  assign err = !(zero || flip);
  // non-legal disparity forces RD to the sign of d
  assign rd_out = zero ? rd_in : flip ? ~rd_in : (d_q[DW-1] ? RD_MINUS : RD_PLUS);
endmodule

// File: rtl/rd_tracker_multi.sv
// rd_tracker_multi: multi-lane 8b10b running-disparity tracker with saturating error count
module rd_tracker_multi
  import rd_tracker_multi_pkg::*;
#(
  parameter int LANES = 4,
  parameter int SYM_W = 10,
  parameter int MODE = 0,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic [LANES*SYM_W-1:0] i_sym,
  input  logic                   i_rd_load,
  input  logic [LANES-1:0]       i_rd_init,
  input  logic                   i_cnt_clr,
  output logic                   o_valid,
  output logic [LANES-1:0]       o_rd,
  output logic [LANES-1:0]       o_disp_err,
  output logic [CNT_W-1:0]       o_err_cnt
);
  localparam int DW = disp_w(SYM_W);
  localparam int EW = $clog2(LANES + 1);
  localparam int SW = CNT_W + EW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic s1_valid;
  logic signed [DW-1:0] d_c [LANES];
  logic signed [DW-1:0] d_q [LANES];
  logic [LANES-1:0] rd_q, rd_eff, rd_out, err, rd_next;
  logic [EW-1:0] n_err;
  logic [SW-1:0] sum;
  // a load in the same cycle as a stage-2 word becomes that word's entry RD
  assign rd_eff = i_rd_load ? (MODE == MODE_CHAIN ? {LANES{i_rd_init[0]}} : i_rd_init) : rd_q;
  genvar k;
  for (k = 0; k < LANES; k++) begin : g_lane
    logic ri, ro;
    if (MODE == MODE_CHAIN && k > 0) begin : g_chain
      assign ri = g_lane[k-1].ro;
    end else begin : g_own
      assign ri = rd_eff[k];
    end
    sym_disp_step #(.SYM_W(SYM_W), .DW(DW)) u_step (
      .sym(i_sym[k*SYM_W +: SYM_W]),
      .d(d_c[k]),
      .d_q(d_q[k]),
      .rd_in(ri),
      .rd_out(ro),
      .err(err[k])
    );
    assign rd_out[k] = ro;
  end
  always_comb begin
    rd_next = i_rd_load ? rd_eff : !s1_valid ? rd_q :
              MODE == MODE_CHAIN ? {LANES{rd_out[LANES-1]}} : rd_out;
    n_err = '0;
    for (int i = 0; i < LANES; i++) n_err = n_err + EW'(err[i]);
    sum = SW'(o_err_cnt) + SW'(n_err);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      d_q <= '{default: '0};
      rd_q <= '0;
      o_valid <= 1'b0;
      o_rd <= '0;
      o_disp_err <= '0;
      o_err_cnt <= '0;
    end else begin
      s1_valid <= i_valid;
      d_q <= d_c;
      rd_q <= rd_next;
      o_valid <= s1_valid;
      o_disp_err <= s1_valid ? err : '0;
      if (s1_valid) o_rd <= rd_out;
      o_err_cnt <= i_cnt_clr ? '0 : !s1_valid ? o_err_cnt :
                   sum > SW'(CNT_MAX) ? CNT_MAX : sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_rd_tracker_multi.sv
// tb_rd_tracker_multi: randomized and directed checks of three tracker configurations against a word-level model
module tb_rd_tracker_multi;
  logic clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, i_rd_load = 1'b0, i_cnt_clr = 1'b0;
  logic [39:0] i_sym = '0;
  logic [3:0] i_rd_init = '0;
  logic ov [3];
  logic [3:0] ordv [3];
  logic [3:0] oerr [3];
  logic [15:0] ocnt [3];
  logic [3:0] cnt4;
  int nvec = 0, nmiss = 0;
  localparam logic [9:0] SP = 10'b0011111010, SN = 10'b1100000101, SZ = 10'b1010101010, S10 = 10'b1111111111;
  int mode_of [3] = '{0, 1, 0};
  int cmax [3] = '{65535, 65535, 15};
  logic [3:0] m_rd [3];
  int m_cnt [3];
  logic e_valid [3];
  logic [3:0] e_rd [3];
  logic [3:0] e_err [3];
  logic p_valid;
  logic [39:0] p_sym;

  always #5 clk = ~clk;

  rd_tracker_multi #(.LANES(4), .SYM_W(10), .MODE(0), .CNT_W(16)) u_indep (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sym(i_sym), .i_rd_load(i_rd_load),
    .i_rd_init(i_rd_init), .i_cnt_clr(i_cnt_clr), .o_valid(ov[0]), .o_rd(ordv[0]),
    .o_disp_err(oerr[0]), .o_err_cnt(ocnt[0]));
  rd_tracker_multi #(.LANES(4), .SYM_W(10), .MODE(1), .CNT_W(16)) u_chain (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sym(i_sym), .i_rd_load(i_rd_load),
    .i_rd_init(i_rd_init), .i_cnt_clr(i_cnt_clr), .o_valid(ov[1]), .o_rd(ordv[1]),
    .o_disp_err(oerr[1]), .o_err_cnt(ocnt[1]));
  rd_tracker_multi #(.LANES(4), .SYM_W(10), .MODE(0), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sym(i_sym), .i_rd_load(i_rd_load),
    .i_rd_init(i_rd_init), .i_cnt_clr(i_cnt_clr), .o_valid(ov[2]), .o_rd(ordv[2]),
    .o_disp_err(oerr[2]), .o_err_cnt(cnt4));
  assign ocnt[2] = {12'h0, cnt4};

  // lane-by-lane 8b10b disparity rules applied to one whole word
  function automatic void judge(input int mode, input logic [3:0] entry, input logic [39:0] sym,
                                output logic [3:0] ex, output logic [3:0] er);
    int d;
    logic r;
    ex = '0;
    er = '0;
    for (int k = 0; k < 4; k++) begin
      d = 2 * $countones(sym[k*10 +: 10]) - 10;
      r = (mode == 1 && k > 0) ? ex[k-1] : entry[k];
      if (d == 0) begin ex[k] = r; er[k] = 1'b0; end
      else if ((d == 2 && !r) || (d == -2 && r)) begin ex[k] = !r; er[k] = 1'b0; end
      else begin ex[k] = d > 0; er[k] = 1'b1; end
    end
  endfunction

  task automatic model_reset;
    for (int m = 0; m < 3; m++) begin
      m_rd[m] = '0; m_cnt[m] = 0; e_valid[m] = 1'b0; e_rd[m] = '0; e_err[m] = '0;
    end
    p_valid = 1'b0;
    p_sym = '0;
  endtask

  task automatic tick;
    logic [3:0] ent, ex, er;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      for (int m = 0; m < 3; m++) begin
        ent = i_rd_load ? (mode_of[m] == 1 ? {4{i_rd_init[0]}} : i_rd_init) : m_rd[m];
        ex = '0;
        e_valid[m] = p_valid;
        e_err[m] = '0;
        if (p_valid) begin
          judge(mode_of[m], ent, p_sym, ex, er);
          e_err[m] = er;
          e_rd[m] = ex;
          m_cnt[m] = m_cnt[m] + $countones(er);
          if (m_cnt[m] > cmax[m]) m_cnt[m] = cmax[m];
        end
        if (i_cnt_clr) m_cnt[m] = 0;
        m_rd[m] = i_rd_load ? ent : !p_valid ? m_rd[m] : mode_of[m] == 1 ? {4{ex[3]}} : ex;
      end
      p_valid = i_valid;
      p_sym = i_sym;
    end
    #1;
  endtask

  task automatic send(input logic [39:0] s);
    i_valid = 1'b1;
    i_sym = s;
    tick();
    i_valid = 1'b0;
  endtask

  function automatic logic [9:0] pick_sym();
    int c;
    c = $urandom_range(0, 4);
    return c == 0 ? SP : c == 1 ? SN : c == 2 ? SZ : c == 3 ? S10 : 10'($urandom);
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 3; m++) begin
      nvec++;
      if (ov[m] !== 1'b0 || ordv[m] !== 4'b0 || oerr[m] !== 4'b0 || ocnt[m] !== 16'd0) begin
        nmiss++;
        $display("FAIL reset m=%0d got v=%b rd=%b err=%b cnt=%0d exp all zero", m, ov[m], ordv[m], oerr[m], ocnt[m]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_indep;
    send({4{SP}});
    tick();
    nvec++;
    if (ov[0] !== 1'b1 || ordv[0] !== 4'b1111 || oerr[0] !== 4'b0000) begin
      nmiss++;
      $display("FAIL indep_first got v=%b rd=%b err=%b exp v=1 rd=1111 err=0000", ov[0], ordv[0], oerr[0]);
    end
    send({4{SP}});
    tick();
    nvec++;
    if (oerr[0] !== 4'b1111 || ordv[0] !== 4'b1111 || ocnt[0] !== 16'd4) begin
      nmiss++;
      $display("FAIL indep_repeat got rd=%b err=%b cnt=%0d exp rd=1111 err=1111 cnt=4", ordv[0], oerr[0], ocnt[0]);
    end
    nvec++;
    if (oerr[1] !== e_err[1] || ordv[1] !== e_rd[1] || ocnt[1] !== 16'(m_cnt[1])) begin
      nmiss++;
      $display("FAIL indep_chain_inst got rd=%b err=%b cnt=%0d exp rd=%b err=%b cnt=%0d", ordv[1], oerr[1], ocnt[1], e_rd[1], e_err[1], m_cnt[1]);
    end
  endtask

  task automatic test_chain;
    i_rd_load = 1'b1;
    i_rd_init = 4'b0000;
    tick();
    i_rd_load = 1'b0;
    send({SN, SP, SN, SP});
    tick();
    nvec++;
    if (ov[1] !== 1'b1 || ordv[1] !== 4'b0101 || oerr[1] !== 4'b0000) begin
      nmiss++;
      $display("FAIL chain_alt got v=%b rd=%b err=%b exp v=1 rd=0101 err=0000", ov[1], ordv[1], oerr[1]);
    end
    send({4{SZ}});
    tick();
    nvec++;
    if (ordv[1][0] !== 1'b0 || oerr[1] !== 4'b0000) begin
      nmiss++;
      $display("FAIL chain_neutral got rd=%b err=%b exp rd[0]=0 err=0000", ordv[1], oerr[1]);
    end
  endtask

  task automatic test_lane2;
    int c0;
    c0 = m_cnt[0];
    send({SZ, S10, SZ, SZ});
    tick();
    nvec++;
    if (oerr[0] !== 4'b0100 || ordv[0][2] !== 1'b1 || ocnt[0] !== 16'(c0 + 1)) begin
      nmiss++;
      $display("FAIL lane2_err got rd=%b err=%b cnt=%0d exp rd[2]=1 err=0100 cnt=%0d", ordv[0], oerr[0], ocnt[0], c0 + 1);
    end
  endtask

  task automatic test_sat;
    i_valid = 1'b1;
    i_sym = {4{S10}};
    repeat (6) tick();
    i_valid = 1'b0;
    repeat (2) tick();
    nvec++;
    if (ocnt[2] !== 16'd15) begin
      nmiss++;
      $display("FAIL sat_reach got cnt=%0d exp 15", ocnt[2]);
    end
    send({4{S10}});
    tick();
    nvec++;
    if (ocnt[2] !== 16'd15 || ocnt[0] !== 16'(m_cnt[0])) begin
      nmiss++;
      $display("FAIL sat_hold got cnt2=%0d cnt0=%0d exp 15 and %0d", ocnt[2], ocnt[0], m_cnt[0]);
    end
    send({4{S10}});
    i_cnt_clr = 1'b1;
    tick();
    i_cnt_clr = 1'b0;
    for (int m = 0; m < 3; m++) begin
      nvec++;
      if (ocnt[m] !== 16'd0 || oerr[m] !== 4'b1111) begin
        nmiss++;
        $display("FAIL clr_priority m=%0d got cnt=%0d err=%b exp cnt=0 err=1111", m, ocnt[m], oerr[m]);
      end
    end
  endtask

  task automatic test_load;
    i_rd_load = 1'b1;
    i_rd_init = 4'b1010;
    tick();
    i_rd_load = 1'b0;
    send({4{SZ}});
    tick();
    nvec++;
    if (ordv[0] !== 4'b1010 || oerr[0] !== 4'b0000) begin
      nmiss++;
      $display("FAIL load_plain got rd=%b err=%b exp rd=1010 err=0000", ordv[0], oerr[0]);
    end
    i_rd_load = 1'b1;
    i_rd_init = 4'b0000;
    tick();
    i_rd_load = 1'b0;
    send({4{SP}});
    i_rd_load = 1'b1;
    i_rd_init = 4'b1010;
    tick();
    i_rd_load = 1'b0;
    nvec++;
    if (ordv[0] !== 4'b1111 || oerr[0] !== 4'b1010) begin
      nmiss++;
      $display("FAIL load_coincident got rd=%b err=%b exp rd=1111 err=1010", ordv[0], oerr[0]);
    end
    nvec++;
    if (ordv[1] !== e_rd[1] || oerr[1] !== e_err[1]) begin
      nmiss++;
      $display("FAIL load_chain got rd=%b err=%b exp rd=%b err=%b", ordv[1], oerr[1], e_rd[1], e_err[1]);
    end
    send({4{SZ}});
    tick();
    nvec++;
    if (ordv[0] !== 4'b1010 || oerr[0] !== 4'b0000) begin
      nmiss++;
      $display("FAIL load_wins got rd=%b err=%b exp rd=1010 err=0000", ordv[0], oerr[0]);
    end
  endtask

  task automatic test_reset_midflight;
    i_valid = 1'b1;
    i_sym = {SP, SN, S10, SZ};
    tick();
    i_sym = {S10, S10, SP, SP};
    #2;
    rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) begin
      nvec++;
      if (ov[m] !== 1'b0 || ordv[m] !== 4'b0 || oerr[m] !== 4'b0 || ocnt[m] !== 16'd0) begin
        nmiss++;
        $display("FAIL async_reset m=%0d got v=%b rd=%b err=%b cnt=%0d exp all zero", m, ov[m], ordv[m], oerr[m], ocnt[m]);
      end
    end
    model_reset();
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      for (int m = 0; m < 3; m++) begin
        nvec++;
        if (ov[m] !== 1'b0 || ordv[m] !== 4'b0 || ocnt[m] !== 16'd0) begin
          nmiss++;
          $display("FAIL post_reset m=%0d got v=%b rd=%b cnt=%0d exp v=0 rd=0 cnt=0", m, ov[m], ordv[m], ocnt[m]);
        end
      end
    end
  endtask

  task automatic test_random;
    repeat (400) begin
      i_valid = $urandom_range(0, 2) != 0;
      i_sym = {pick_sym(), pick_sym(), pick_sym(), pick_sym()};
      i_rd_load = $urandom_range(0, 15) == 0;
      i_rd_init = 4'($urandom);
      i_cnt_clr = $urandom_range(0, 31) == 0;
      tick();
      for (int m = 0; m < 3; m++) begin
        nvec++;
        if (ov[m] !== e_valid[m] || ordv[m] !== e_rd[m] || oerr[m] !== e_err[m] || ocnt[m] !== 16'(m_cnt[m])) begin
          nmiss++;
          $display("FAIL random m=%0d got v=%b rd=%b err=%b cnt=%0d exp v=%b rd=%b err=%b cnt=%0d",
                   m, ov[m], ordv[m], oerr[m], ocnt[m], e_valid[m], e_rd[m], e_err[m], m_cnt[m]);
        end
      end
    end
    i_valid = 1'b0;
    i_rd_load = 1'b0;
    i_cnt_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_indep();
    test_chain();
    test_lane2();
    test_sat();
    test_load();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end
endmodule
